// File: rtl/operand_stack.sv
// operand_stack: single-clock LIFO operand stack for the CPU control unit, with
// combinational tos/nos peek ports, a registered pop output and sticky error flags.
// Latency: push is visible on tos/count right after the edge; popped data arrives
// one cycle after the pop strobe.
// Backpressure: none. A push on full or a pop on empty is dropped and sets a sticky
// flag instead.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   push, pop, clear        one-cycle strobes (clear empties the stack and drops flags)
//   data_in                 value to push
//   data_out, out_valid     registered popped value; out_valid pulses for one cycle
//   tos, nos                top / next-of-stack, forced to 0 when not present
//   count, empty, full      occupancy status
//   overflow, underflow     sticky error flags, cleared by reset or clear
module operand_stack #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    sp;

   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    nos_idx;
   logic [AW-1:0]    wr_idx;
   logic             wr_en;

   // Indices are taken modulo DEPTH: when sp == DEPTH the low bits wrap to 0,
   // and subtracting 1 or 2 still lands on the correct slot.
   assign top_idx = sp[AW-1:0] - AW'(1);
   assign nos_idx = sp[AW-1:0] - AW'(2);

   assign empty = (sp == '0);
   assign full  = (sp == CW'(DEPTH));
   assign count = sp;

   assign tos = empty           ? '0 : mem[top_idx];
   assign nos = (sp < CW'(2))   ? '0 : mem[nos_idx];

   // A push writes either the free slot (push only) or overwrites the top
   // entry (replace). The bypass case on an empty stack never touches mem.
   assign wr_en  = !reset && !clear && push && (pop ? !empty : !full);
   assign wr_idx = pop ? top_idx : sp[AW-1:0];

   // Storage is deliberately not reset; stale entries are masked on tos/nos.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp        <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         sp        <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case ({push, pop})
            2'b10: begin
               if (full) begin
                  overflow <= 1'b1;
               end else begin
                  sp <= sp + CW'(1);
               end
            end
            2'b01: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  data_out  <= mem[top_idx];
                  out_valid <= 1'b1;
                  sp        <= sp - CW'(1);
               end
            end
            2'b11: begin
               // Replace returns the old top; on an empty stack the pushed
               // value passes straight through to data_out.
               data_out  <= empty ? data_in : mem[top_idx];
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             push;
   logic             pop;
   logic             clear;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] sb [$];

   operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .clear     (clear),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .tos       (tos),
      .nos       (nos),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus. If a popped value is expected, it is queued now
   // and compared when out_valid appears after the edge.
   task automatic op(input logic p, input logic q, input logic c, input logic r,
                     input logic [WIDTH-1:0] d, input logic ev, input logic [WIDTH-1:0] ed);
      push = p; pop = q; clear = c; reset = r; data_in = d;
      if (ev) sb.push_back(ed);
      @(posedge clk);
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (out_valid) begin
         chk("sb_pending", sb.size(), 1);
         if (sb.size() > 0) chk("data_out", {24'b0, data_out}, {24'b0, sb.pop_front()});
      end else begin
         sb.delete();
      end
      push = 1'b0; pop = 1'b0; clear = 1'b0; reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic status(input string tag, input int exp_count,
                         input logic [WIDTH-1:0] exp_tos, input logic [WIDTH-1:0] exp_nos);
      chk({tag, ".count"}, {27'b0, count}, exp_count);
      chk({tag, ".tos"}, {24'b0, tos}, {24'b0, exp_tos});
      chk({tag, ".nos"}, {24'b0, nos}, {24'b0, exp_nos});
      chk({tag, ".empty"}, {31'b0, empty}, (exp_count == 0) ? 32'd1 : 32'd0);
      chk({tag, ".full"}, {31'b0, full}, (exp_count == DEPTH) ? 32'd1 : 32'd0);
   endtask

   task automatic flags(input string tag, input logic exp_ov, input logic exp_un);
      chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, exp_ov});
      chk({tag, ".underflow"}, {31'b0, underflow}, {31'b0, exp_un});
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      status("reset", 0, 8'h00, 8'h00);
      flags("reset", 1'b0, 1'b0);
      chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset.data_out", {24'b0, data_out}, 32'd0);

      // Three pushes
      op(1, 0, 0, 0, 8'h11, 0, 8'h00);
      op(1, 0, 0, 0, 8'h22, 0, 8'h00);
      op(1, 0, 0, 0, 8'h33, 0, 8'h00);
      status("push3", 3, 8'h33, 8'h22);

      // Back-to-back pops return TOS then NOS
      op(0, 1, 0, 0, 8'h00, 1, 8'h33);
      op(0, 1, 0, 0, 8'h00, 1, 8'h22);
      status("pop2", 1, 8'h11, 8'h00);
      op(0, 0, 0, 0, 8'h00, 0, 8'h00);
      op(0, 1, 0, 0, 8'h00, 1, 8'h11);
      status("drained", 0, 8'h00, 8'h00);

      // Fill to DEPTH, then overflow push must not disturb contents
      for (int i = 0; i < DEPTH; i++) op(1, 0, 0, 0, 8'(i), 0, 8'h00);
      status("filled", DEPTH, 8'h0F, 8'h0E);
      flags("filled", 1'b0, 1'b0);
      op(1, 0, 0, 0, 8'hAA, 0, 8'h00);
      status("overflow", DEPTH, 8'h0F, 8'h0E);
      flags("overflow", 1'b1, 1'b0);

      // Pop down to four entries; overflow stays sticky
      for (int i = DEPTH - 1; i >= 4; i--) op(0, 1, 0, 0, 8'h00, 1, 8'(i));
      status("pop_to4", 4, 8'h03, 8'h02);
      flags("pop_to4", 1'b1, 1'b0);

      // Clear wins over a simultaneous push; data_out holds
      op(1, 0, 1, 0, 8'h77, 0, 8'h00);
      status("clear", 0, 8'h00, 8'h00);
      flags("clear", 1'b0, 1'b0);
      chk("clear.data_out_hold", {24'b0, data_out}, 32'h04);

      // Underflow, then bypass on empty
      op(0, 1, 0, 0, 8'h00, 0, 8'h00);
      status("underflow", 0, 8'h00, 8'h00);
      flags("underflow", 1'b0, 1'b1);
      chk("underflow.data_out_hold", {24'b0, data_out}, 32'h04);
      op(1, 1, 0, 0, 8'h5C, 1, 8'h5C);
      status("bypass", 0, 8'h00, 8'h00);
      flags("bypass", 1'b0, 1'b1);

      // Replace on a two-entry stack
      op(1, 0, 0, 0, 8'h05, 0, 8'h00);
      op(1, 0, 0, 0, 8'h07, 0, 8'h00);
      status("pre_replace", 2, 8'h07, 8'h05);
      op(1, 1, 0, 0, 8'h09, 1, 8'h07);
      status("replace", 2, 8'h09, 8'h05);

      // Reset while popping discards the pop
      op(0, 1, 0, 0, 8'h00, 1, 8'h09);
      op(0, 1, 0, 1, 8'h00, 0, 8'h00);
      status("reset_mid", 0, 8'h00, 8'h00);
      flags("reset_mid", 1'b0, 1'b0);
      chk("reset_mid.data_out", {24'b0, data_out}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
